// File: rtl/classify_ctrl_if.sv
// Handshake bundle for classify_ctrl: start/abort control, the shared
// output-neuron launch/return pair, and the class result handshake.
interface classify_ctrl_if #(
  parameter int SCORE_W = 26,
  parameter int IDX_W   = 4
);
  logic               Start;
  logic               Abort;
  logic               Neuron_Start;
  logic [IDX_W-1:0]   Neuron_Sel;
  logic               Neuron_Done;
  logic [SCORE_W-1:0] Neuron_Out;
  logic               Busy;
  logic               Class_Valid;
  logic [IDX_W-1:0]   Class_Out;
  logic [SCORE_W-1:0] Max_Score;
  logic               Class_Ack;

  modport master (
    input  Start, Abort, Neuron_Done, Neuron_Out, Class_Ack,
    output Neuron_Start, Neuron_Sel, Busy, Class_Valid, Class_Out, Max_Score
  );

  modport slave (
    output Start, Abort, Neuron_Done, Neuron_Out, Class_Ack,
    input  Neuron_Start, Neuron_Sel, Busy, Class_Valid, Class_Out, Max_Score
  );
endinterface

// File: rtl/classify_ctrl.sv
// Sequences one shared output neuron over all classes and keeps a running
// signed maximum; the winning index is presented with a valid/ack handshake.
//
// state | meaning
// IDLE  | waiting for Start
// ISSUE | one-cycle launch of the neuron on class idx_q
// WAIT  | waiting for Neuron_Done, then compare/update running max
// DONE  | result presented, held until Class_Ack
module classify_ctrl #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 26,
  parameter int IDX_W       = 4
) (
  input logic             clk,
  input logic             GlobalReset,
  classify_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic [IDX_W-1:0]   class_out_q, class_out_d;
  logic [SCORE_W-1:0] max_score_q, max_score_d;

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      class_out_q <= '0;
      max_score_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      class_out_q <= class_out_d;
      max_score_q <= max_score_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    class_out_d = class_out_q;
    max_score_d = max_score_q;

    if (bus.Abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.Start) begin
            state_d = ISSUE;
            idx_d   = '0;
          end
        end
        ISSUE: state_d = WAIT;
        WAIT: begin
          if (bus.Neuron_Done) begin
            // Strict greater-than keeps the lowest index on ties.
            if (idx_q == '0 || $signed(bus.Neuron_Out) > $signed(best_q)) begin
              best_d     = bus.Neuron_Out;
              best_idx_d = idx_q;
            end
            if (idx_q == LAST_IDX) begin
              state_d     = DONE;
              class_out_d = best_idx_d;
              max_score_d = best_d;
            end else begin
              state_d = ISSUE;
              idx_d   = idx_q + IDX_W'(1);
            end
          end
        end
        DONE: begin
          if (bus.Class_Ack) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.Neuron_Start = (state_q == ISSUE);
  assign bus.Neuron_Sel   = idx_q;
  assign bus.Busy         = (state_q != IDLE);
  assign bus.Class_Valid  = (state_q == DONE);
  assign bus.Class_Out    = class_out_q;
  assign bus.Max_Score    = max_score_q;

endmodule

// File: doc/classify_ctrl.md
# classify_ctrl

Sequencer and running-max argmax engine for the output layer. Steps one shared output-neuron unit through class indices 0..NUM_CLASSES-1, compares each returned signed score against the best so far, and presents the winning class index with a valid/ack handshake. Sits between the output-layer neuron and the top-level result port. It replaces the ten-wide parallel compare tree with one comparator and one score register.

## Interface
- NUM_CLASSES, 10, number of output classes. Legal range 2..16.
- SCORE_W, 26, score width, two's complement.
- IDX_W, 4, class index width. Must satisfy 2^IDX_W >= NUM_CLASSES.
- clk  in  1  sole clock; all state changes on its rising edge.
- GlobalReset  in  1  asynchronous, active-low reset.
- Start  in  1  request one classification. Sampled only in IDLE.
- Abort  in  1  synchronous abort. Returns to IDLE from any state.
- Neuron_Start  out  1  one-cycle pulse that launches the neuron unit on Neuron_Sel.
- Neuron_Sel  out  IDX_W  class index the neuron unit evaluates.
- Neuron_Done  in  1  neuron result valid, one-cycle pulse.
- Neuron_Out  in  SCORE_W  neuron score. Valid only with Neuron_Done.
- Busy  out  1  high in every state except IDLE.
- Class_Valid  out  1  result valid. Held until acknowledged.
- Class_Out  out  IDX_W  winning class index.
- Max_Score  out  SCORE_W  winning score.
- Class_Ack  in  1  consumer accepts the result.

## Operation
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered or decoded directly from state flops. No combinational path runs from inputs to outputs.
- IDLE
  - Busy=0. Start=1 -> ISSUE; Idx<=0.
- ISSUE (exactly one cycle)
  - Neuron_Start=1 and Neuron_Sel=Idx -> WAIT.
- WAIT
  - Neuron_Sel holds Idx. The block stays in WAIT until Neuron_Done=1.
  - On Done, with Idx==0: Best<=Neuron_Out, Best_Idx<=0.
  - On Done, with Idx>0: update Best and Best_Idx only when Neuron_Out > Best under a signed compare.
  - Tie rule: strict greater-than, so on equal scores the lowest index wins.
  - Then, if Idx==NUM_CLASSES-1 -> DONE; else Idx<=Idx+1 -> ISSUE.
- DONE
  - Class_Valid=1. Class_Out=Best_Idx and Max_Score=Best, both stable for the whole state.
  - Class_Ack=1 -> IDLE. Class_Out and Max_Score keep their values after exit until the next update.
- Signed compare: the MSB is the sign. Any non-negative score beats any negative score. Among negatives, the value closer to zero wins. Example: 26'h3FFFFFF (-1) beats 26'h2000000 (most negative).
- Ignored events:
  - Start outside IDLE.
  - Neuron_Done outside WAIT, including Done coincident with Neuron_Start in ISSUE.
  - Class_Ack outside DONE.
- Abort: takes priority over every other transition. Next state IDLE, Class_Valid=0, Neuron_Start=0. Best and Best_Idx are not updated in that cycle.
- Reset (GlobalReset=0, any time, including mid-sequence): state=IDLE.
  - All outputs go to 0 immediately: Neuron_Start, Neuron_Sel, Busy, Class_Valid, Class_Out, Max_Score.
  - Idx, Best and Best_Idx go to 0.
  - The neuron unit is expected to be reset by the same signal.

## Timing
- Cycle numbering: edge n ends cycle n.
- Start high in cycle 0 -> ISSUE in cycle 1, with Neuron_Start high for that cycle only.
- Per class: 1 ISSUE cycle + (L+1) WAIT cycles, where L = number of WAIT cycles before Done.
- Total latency from Start to Class_Valid is NUM_CLASSES*(2+L)+1 cycles. With L=0 and NUM_CLASSES=10, Class_Valid first goes high in cycle 21.
- Class_Valid falls in the cycle after the one in which Class_Ack is high.
- Start may be reasserted in the first IDLE cycle. A back-to-back classification therefore costs at least one idle cycle.
- Busy rises in the cycle after Start is accepted. It falls in the cycle after Class_Ack, or after Abort.
- Neuron_Sel changes only when entering ISSUE, and is stable through the following WAIT.

## Test plan
- Single maximum: neuron returns scores {5,9,3,100,7,2,0,1,8,4} with L=0 -> Class_Out=3, Max_Score=100, Class_Valid first high in cycle 21.
- All negative with a tie: scores {-50,-3,-3,-900,-7,-1,-1,-20,-2,-100} -> Class_Out=5 (the lower index of the tied -1 pair), Max_Score=26'h3FFFFFF.
- Sign boundary: score 0 at index 9 and 26'h2000000 at indices 0..8 -> Class_Out=9. Then 26'h1FFFFFF at index 0 and 0 elsewhere -> Class_Out=0.
- Variable latency: Done delayed by 0, 3 and 7 cycles on alternate classes.
  - Neuron_Start is pulsed exactly 10 times, each 1 cycle wide.
  - Neuron_Sel steps through 0..9 and holds during each WAIT.
  - A spurious Done in IDLE or ISSUE does not change Best.
- Handshake: hold Class_Ack low for 5 cycles in DONE -> outputs stable and a second Start is ignored. Assert Ack -> Class_Valid=0 and Busy=0 on the next cycle, after which a new Start is accepted.
- Abort and reset: Abort during WAIT at index 4 -> IDLE next cycle, Class_Valid never asserted, and a restarted run gives the correct result. GlobalReset pulsed low mid-ISSUE -> all outputs 0 immediately, without waiting for a clock edge.
